// File: rtl/apb_regbank_slave.sv
// APB3/APB4 slave register bank: CTRL (wait states), saturating ERRCNT and
// general byte-lane-writable registers, with registered PREADY/PSLVERR/PRDATA.
`timescale 1ns/1ps

module apb_regbank_slave #(
  parameter int PADDR_SIZE = 10,
  parameter int PDATA_SIZE = 8,
  parameter int NUM_REGS   = 16
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic [2:0]                     PPROT,
  input  logic                           PWRITE,
  input  logic [PDATA_SIZE/8-1:0]        PSTRB,
  input  logic [PADDR_SIZE-1:0]          PADDR,
  input  logic [PDATA_SIZE-1:0]          PWDATA,
  output logic [PDATA_SIZE-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*PDATA_SIZE-1:0] REG_Q
);

  localparam int STRB_W   = PDATA_SIZE / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = PADDR_SIZE - ADDR_LSB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    write_q, write_d;
  logic [STRB_W-1:0]       strb_q, strb_d;
  logic [PDATA_SIZE-1:0]   wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic [PDATA_SIZE-1:0]   prdata_q, prdata_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [PDATA_SIZE-1:0]   regs_q [NUM_REGS];
  logic [PDATA_SIZE-1:0]   regs_d [NUM_REGS];

  logic                    setup;
  logic [IDX_W-1:0]        setup_idx;
  logic                    setup_err;
  logic [3:0]              ctrl_wait;
  logic                    ready_fire;
  logic                    commit;
  logic [IDX_W-1:0]        sel_idx;
  logic                    sel_err;
  logic [PDATA_SIZE-1:0]   rd_word;
  logic                    unused_inputs;

  // Upper PPROT bits carry no meaning here; low PADDR bits are folded away too.
  assign unused_inputs = ^{PPROT[2:1], PADDR};

  assign setup     = PSEL && !PENABLE;
  assign setup_idx = PADDR[PADDR_SIZE-1:ADDR_LSB];
  assign ctrl_wait = regs_q[0][3:0];

  always_comb begin
    setup_err = 1'b0;
    if ({1'b0, setup_idx} >= (IDX_W+1)'(NUM_REGS)) begin
      setup_err = 1'b1;
    end
    if (PWRITE && (setup_idx == IDX_W'(1))) begin
      setup_err = 1'b1;
    end
    if (PWRITE && (setup_idx == '0) && !PPROT[0]) begin
      setup_err = 1'b1;
    end
  end

  // A zero-wait transfer fetches its read data straight from the setup inputs.
  always_comb begin
    if (state_q == ST_IDLE) begin
      sel_idx = setup_idx;
      sel_err = setup_err;
    end else begin
      sel_idx = idx_q;
      sel_err = err_q;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        rd_word = regs_q[i];
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      write_q   <= 1'b0;
      strb_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      wcnt_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      regs_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      strb_q    <= strb_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      wcnt_q    <= wcnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      regs_q    <= regs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          state_d = (ctrl_wait == 4'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (wcnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready_fire = ((state_q == ST_IDLE) && setup && (ctrl_wait == 4'd0)) ||
                      ((state_q == ST_WAIT) && PSEL && (wcnt_q == 4'd1));
  assign commit     = (state_q == ST_RESP) && PSEL;

  always_comb begin
    idx_d     = idx_q;
    write_d   = write_q;
    strb_d    = strb_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    wcnt_d    = wcnt_q;
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    regs_d    = regs_q;

    if ((state_q == ST_IDLE) && setup) begin
      idx_d   = setup_idx;
      write_d = PWRITE;
      strb_d  = PSTRB;
      wdata_d = PWDATA;
      err_d   = setup_err;
      wcnt_d  = ctrl_wait;
    end

    if ((state_q == ST_WAIT) && PSEL) begin
      wcnt_d = wcnt_q - 4'd1;
    end

    if (ready_fire) begin
      pready_d  = 1'b1;
      pslverr_d = sel_err;
      prdata_d  = sel_err ? '0 : rd_word;
    end

    // Erroring transfers never write, so ERRCNT and a lane write cannot collide.
    if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (write_q && !err_q && (idx_q == IDX_W'(i)) && strb_q[b]) begin
            regs_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
          end
        end
      end
      if (pslverr_q && (regs_q[1] != '1)) begin
        regs_d[1] = regs_q[1] + 1'b1;
      end
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

  always_comb begin
    REG_Q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      REG_Q[i*PDATA_SIZE +: PDATA_SIZE] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Scoreboard bench for apb_regbank_slave: transfers push expected PRDATA/PSLVERR,
// a negedge monitor pops and compares whenever PREADY is high.
`timescale 1ns/1ps

module tb_apb_regbank_slave;

  logic         PCLK;
  logic         PRESETn;
  logic         PSEL;
  logic         PENABLE;
  logic [2:0]   PPROT;
  logic         PWRITE;
  logic [0:0]   PSTRB;
  logic [9:0]   PADDR;
  logic [7:0]   PWDATA;
  logic [7:0]   PRDATA;
  logic         PREADY;
  logic         PSLVERR;
  logic [127:0] REG_Q;

  int           checks = 0;
  int           errors = 0;
  logic [8:0]   exp_q[$];
  logic [8:0]   mon_exp;

  apb_regbank_slave #(
    .PADDR_SIZE(10),
    .PDATA_SIZE(8),
    .NUM_REGS(16)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PPROT(PPROT),
    .PWRITE(PWRITE),
    .PSTRB(PSTRB),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .PSLVERR(PSLVERR),
    .REG_Q(REG_Q)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every PREADY pulse must match the oldest outstanding expectation.
  always @(negedge PCLK) begin
    if (PREADY === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pready: got PREADY=1 PRDATA=%0h PSLVERR=%0b expected no completion",
                 PRDATA, PSLVERR);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("prdata", {120'd0, PRDATA}, {120'd0, mon_exp[8:1]});
        checkOutput("pslverr", {127'd0, PSLVERR}, {127'd0, mon_exp[0]});
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the completion edge so the
  // next call forms a back-to-back transfer.
  task automatic applyStimulus(input string tag, input logic wr, input logic [9:0] addr,
                               input logic [7:0] wdata, input logic strb, input logic [2:0] prot,
                               input logic [7:0] exp_data, input logic exp_err, input int exp_wait);
    int  cycles;
    logic done;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wdata;
    PSTRB   = strb;
    PPROT   = prot;
    exp_q.push_back({exp_data, exp_err});
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < 40) begin
      @(negedge PCLK);
      cycles++;
      if (PREADY === 1'b1) done = 1'b1;
    end
    checkOutput({"access_cycles_", tag}, 128'(cycles), 128'(exp_wait + 1));
    @(posedge PCLK); #1;
  endtask

  task automatic idleCycle();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    @(posedge PCLK); #1;
  endtask

  task automatic doReset();
    PRESETn = 1'b0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    checkOutput("reset_pready", {127'd0, PREADY}, 128'd0);
    checkOutput("reset_pslverr", {127'd0, PSLVERR}, 128'd0);
    checkOutput("reset_prdata", {120'd0, PRDATA}, 128'd0);
    checkOutput("reset_regq", REG_Q, 128'd0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 1ms");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    PRESETn = 1'b0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PPROT   = 3'b000;
    PWRITE  = 1'b0;
    PSTRB   = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    doReset();

    // Basic read/write on a general register, including an empty-strobe write.
    applyStimulus("rd5_init",  1'b0, 10'h005, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 0);
    applyStimulus("wr5_a5",    1'b1, 10'h005, 8'hA5, 1'b1, 3'b000, 8'h00, 1'b0, 0);
    applyStimulus("rd5_a5",    1'b0, 10'h005, 8'h00, 1'b0, 3'b000, 8'hA5, 1'b0, 0);
    checkOutput("regq_idx5", {120'd0, REG_Q[47:40]}, 128'hA5);
    applyStimulus("wr5_nostrb", 1'b1, 10'h005, 8'hFF, 1'b0, 3'b000, 8'hA5, 1'b0, 0);
    applyStimulus("rd5_keep",  1'b0, 10'h005, 8'h00, 1'b0, 3'b000, 8'hA5, 1'b0, 0);

    // Wait states from CTRL, privilege check on CTRL writes.
    applyStimulus("wr_ctrl3",  1'b1, 10'h000, 8'h03, 1'b1, 3'b001, 8'h00, 1'b0, 0);
    applyStimulus("rd2_wait3", 1'b0, 10'h002, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 3);
    applyStimulus("wr_ctrl_unpriv", 1'b1, 10'h000, 8'h00, 1'b1, 3'b000, 8'h00, 1'b1, 3);
    applyStimulus("rd_ctrl",   1'b0, 10'h000, 8'h00, 1'b0, 3'b000, 8'h03, 1'b0, 3);
    checkOutput("regq_ctrl", {120'd0, REG_Q[7:0]}, 128'h03);
    applyStimulus("wr_ctrl0",  1'b1, 10'h000, 8'h00, 1'b1, 3'b001, 8'h03, 1'b0, 3);
    applyStimulus("rd_errcnt1", 1'b0, 10'h001, 8'h00, 1'b0, 3'b000, 8'h01, 1'b0, 0);

    // PENABLE without a setup phase must not start a transfer.
    PSEL    = 1'b1;
    PENABLE = 1'b1;
    PWRITE  = 1'b0;
    PADDR   = 10'h005;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      checkOutput($sformatf("penable_only_%0d", i), {127'd0, PREADY}, 128'd0);
    end
    @(posedge PCLK); #1;
    idleCycle();

    // Error transfers and ERRCNT saturation.
    doReset();
    applyStimulus("rd_oor",    1'b0, 10'h010, 8'h00, 1'b0, 3'b000, 8'h00, 1'b1, 0);
    applyStimulus("wr_errcnt", 1'b1, 10'h001, 8'h55, 1'b1, 3'b001, 8'h00, 1'b1, 0);
    applyStimulus("rd_errcnt2", 1'b0, 10'h001, 8'h00, 1'b0, 3'b000, 8'h02, 1'b0, 0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus("rd_oor_loop", 1'b0, 10'h3FF, 8'h00, 1'b0, 3'b000, 8'h00, 1'b1, 0);
    end
    applyStimulus("rd_errcnt_sat", 1'b0, 10'h001, 8'h00, 1'b0, 3'b000, 8'hFF, 1'b0, 0);
    applyStimulus("wr_errcnt2", 1'b1, 10'h001, 8'h55, 1'b1, 3'b001, 8'h00, 1'b1, 0);
    applyStimulus("rd_errcnt_hold", 1'b0, 10'h001, 8'h00, 1'b0, 3'b000, 8'hFF, 1'b0, 0);
    applyStimulus("wr15_5a",   1'b1, 10'h00F, 8'h5A, 1'b1, 3'b000, 8'h00, 1'b0, 0);
    applyStimulus("rd15_5a",   1'b0, 10'h00F, 8'h00, 1'b0, 3'b000, 8'h5A, 1'b0, 0);

    // Abort during wait states.
    applyStimulus("wr4_11",    1'b1, 10'h004, 8'h11, 1'b1, 3'b000, 8'h00, 1'b0, 0);
    applyStimulus("wr_ctrl3b", 1'b1, 10'h000, 8'h03, 1'b1, 3'b001, 8'h00, 1'b0, 0);
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 10'h004;
    PWDATA  = 8'h3C;
    PSTRB   = 1'b1;
    PPROT   = 3'b000;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    checkOutput("abort_wait_pready", {127'd0, PREADY}, 128'd0);
    @(posedge PCLK); #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    @(negedge PCLK);
    checkOutput("abort_pready", {127'd0, PREADY}, 128'd0);
    checkOutput("abort_idx4", {120'd0, REG_Q[39:32]}, 128'h11);
    @(posedge PCLK); #1;
    applyStimulus("rd4_after_abort", 1'b0, 10'h004, 8'h00, 1'b0, 3'b000, 8'h11, 1'b0, 3);

    // Reset asserted during the wait states of a write.
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 10'h006;
    PWDATA  = 8'h77;
    PSTRB   = 1'b1;
    PPROT   = 3'b000;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
    checkOutput("midreset_pready", {127'd0, PREADY}, 128'd0);
    checkOutput("midreset_regq", REG_Q, 128'd0);
    PRESETn = 1'b1;
    applyStimulus("rd6_after_reset", 1'b0, 10'h006, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 0);

    idleCycle();
    idleCycle();
    checkOutput("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_regbank_slave.md
Name: apb_regbank_slave

Overview:
APB3/APB4 slave register bank that sits directly downstream of the AHB-to-APB bridge on the PCLK side. It consumes the bridge's PSEL/PENABLE/PADDR/PWDATA/PSTRB/PPROT transfers and returns PRDATA/PREADY/PSLVERR. It provides NUM_REGS software registers, with:
- programmable wait states
- a read-only error counter
- privilege-checked control register
- byte-lane writes

All register contents are exported flat for peripheral use.

Parameters:
PADDR_SIZE, 10, APB address width
PDATA_SIZE, 8, APB data width; multiple of 8, >= 8
NUM_REGS, 16, number of registers; >= 3, <= 2**(PADDR_SIZE - log2(PDATA_SIZE/8))

Ports:
PCLK  in  1  clock
PRESETn  in  1  synchronous active-low reset
PSEL  in  1  slave select
PENABLE  in  1  access phase
PPROT  in  3  protection; bit0=privileged
PWRITE  in  1  1=write
PSTRB  in  PDATA_SIZE/8  write byte lanes
PADDR  in  PADDR_SIZE  byte address
PWDATA  in  PDATA_SIZE  write data
PRDATA  out  PDATA_SIZE  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  error, valid with PREADY
REG_Q  out  NUM_REGS*PDATA_SIZE  register contents; reg i at [i*PDATA_SIZE +: PDATA_SIZE]

Behaviour:
- Interface: one clock, PCLK; reset PRESETn is synchronous and active-low, sampled only on the PCLK rising edge.
- Reset: state=ST_IDLE; PRDATA=0, PREADY=0, PSLVERR=0, all registers=0 (REG_Q=0).
- Register map, index = PADDR >> log2(PDATA_SIZE/8):
  - 0 = CTRL: RW; bits[3:0] = WAIT, the number of wait states.
  - 1 = ERRCNT: read-only; saturating count of completed transfers with PSLVERR=1.
  - 2..NUM_REGS-1: general RW.
  - Low address bits below the word offset are ignored.
- Error conditions, evaluated at setup: index >= NUM_REGS; write to ERRCNT; write to CTRL with PPROT[0]=0. Reads never error except out-of-range.
- FSM states: ST_IDLE, ST_WAIT, ST_RESP.
- ST_IDLE:
  - On PSEL=1 & PENABLE=0 (setup phase): latch index, PWRITE, PSTRB, PWDATA and the error flag, and load wcnt = CTRL[3:0].
  - If wcnt==0: go to ST_RESP and set PREADY=1 at the same edge.
  - Else: go to ST_WAIT.
- ST_WAIT:
  - PREADY=0; wcnt decrements each cycle.
  - When wcnt==1, go to ST_RESP and set PREADY=1.
  - The access phase therefore lasts exactly 1+WAIT cycles.
- Ready edge: at the edge PREADY is set, PRDATA is loaded with the register value (0 if error) and PSLVERR with the error flag.
- ST_RESP: this is the completion cycle (PSEL=PENABLE=PREADY=1). At its closing edge:
  - Writes commit per byte lane: lane b is updated iff PSTRB[b]=1 and no error.
  - PSTRB=0 means no change and no error.
  - ERRCNT increments if PSLVERR=1, saturating at all-ones.
  - PREADY, PSLVERR and PRDATA return to 0; state goes to ST_IDLE.
- Back-to-back transfers: a new setup phase may occur in the cycle after completion; that transfer sees the CTRL value written by the preceding transfer.
- Abort: PSEL=0 while in ST_WAIT or ST_RESP returns the FSM to ST_IDLE with no commit, no ERRCNT change, and PREADY/PSLVERR/PRDATA=0.
- PENABLE=1 while in ST_IDLE (no setup seen) is ignored.
- Reset asserted mid-transfer: everything returns to reset values at that edge; no commit.
- PREADY and PSLVERR are registered outputs; no combinational path from inputs to outputs.
- Registers outside the written lanes hold their values. REG_Q reflects a commit in the cycle after the completion edge.

Test Plan:
- Reset, then read idx5 (PADDR=0x005), CTRL=0 -> PREADY=1 in the first access cycle, PRDATA=0x00, PSLVERR=0.
- Write idx5=0xA5 (PSTRB=1), then read idx5 -> PRDATA=0xA5; REG_Q[47:40]=0xA5; PSTRB=0 write of 0xFF leaves 0xA5.
- Privileged write CTRL=0x03 (PPROT=3'b001), then read idx2 -> PREADY low for 3 access cycles and high on the 4th; CTRL write with PPROT=3'b000 -> PSLVERR=1, CTRL unchanged.
- Read PADDR=0x010 (idx16, out of range) and write ERRCNT=0x55 -> both PSLVERR=1 with PRDATA=0; a subsequent ERRCNT read returns 0x02; 300 error transfers -> ERRCNT=0xFF (saturated).
- WAIT=3, write idx4=0x3C, deassert PSEL after 1 wait cycle -> idx4 unchanged, PREADY never 1, FSM idle; the next transfer completes normally.
- Assert PRESETn=0 during the wait states of a write idx6=0x77 -> PREADY=0 and idx6=0 after the reset edge; CTRL=0.
